// File: rtl/dest_reg_pipe.sv
// Destination-register pipeline (EX/MEM, MEM/WB) with operand forwarding selects.
// Optional macro LOAD_USE_DETECT_EN enables the same-cycle load-use stall flag.
module dest_reg_pipe #(
  parameter int ADDR_W     = 5,
  parameter bit ZERO_GUARD = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] wr_addr_ex,
  input  logic              reg_write_ex,
  input  logic              mem_to_reg_ex,
  input  logic              hold_i,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] rs_ex,
  input  logic [ADDR_W-1:0] rt_ex,
  input  logic [ADDR_W-1:0] rs_id,
  input  logic [ADDR_W-1:0] rt_id,
  output logic [ADDR_W-1:0] wr_addr_mem,
  output logic              reg_write_mem,
  output logic              mem_to_reg_mem,
  output logic [ADDR_W-1:0] wr_addr_wb,
  output logic              reg_write_wb,
  output logic              mem_to_reg_wb,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              load_use_stall
);

  logic [ADDR_W-1:0] r_addr_mem;
  logic              r_rw_mem;
  logic              r_m2r_mem;
  logic [ADDR_W-1:0] r_addr_wb;
  logic              r_rw_wb;
  logic              r_m2r_wb;

  // hold_i wins over flush_i; a pending flush simply waits for the hold to drop
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr_mem <= '0;
      r_rw_mem   <= 1'b0;
      r_m2r_mem  <= 1'b0;
      r_addr_wb  <= '0;
      r_rw_wb    <= 1'b0;
      r_m2r_wb   <= 1'b0;
    end else if (!hold_i) begin
      if (flush_i) begin
        r_addr_mem <= '0;
        r_rw_mem   <= 1'b0;
        r_m2r_mem  <= 1'b0;
      end else begin
        r_addr_mem <= wr_addr_ex;
        r_rw_mem   <= reg_write_ex;
        r_m2r_mem  <= mem_to_reg_ex;
      end
      r_addr_wb <= r_addr_mem;
      r_rw_wb   <= r_rw_mem;
      r_m2r_wb  <= r_m2r_mem;
    end
  end

  assign wr_addr_mem    = r_addr_mem;
  assign reg_write_mem  = r_rw_mem;
  assign mem_to_reg_mem = r_m2r_mem;
  assign wr_addr_wb     = r_addr_wb;
  assign reg_write_wb   = r_rw_wb;
  assign mem_to_reg_wb  = r_m2r_wb;

  logic w_mem_ok;
  logic w_wb_ok;
  logic w_hit_mem_a;
  logic w_hit_wb_a;
  logic w_hit_mem_b;
  logic w_hit_wb_b;

  assign w_mem_ok = r_rw_mem & ~(ZERO_GUARD & (r_addr_mem == '0));
  assign w_wb_ok  = r_rw_wb  & ~(ZERO_GUARD & (r_addr_wb  == '0));

  assign w_hit_mem_a = w_mem_ok & (r_addr_mem == rs_ex);
  assign w_hit_wb_a  = w_wb_ok  & (r_addr_wb  == rs_ex);
  assign w_hit_mem_b = w_mem_ok & (r_addr_mem == rt_ex);
  assign w_hit_wb_b  = w_wb_ok  & (r_addr_wb  == rt_ex);

  // MEM holds the newer result, so it takes priority over WB
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (w_hit_mem_a)     fwd_a = 2'b10;
    else if (w_hit_wb_a) fwd_a = 2'b01;
    if (w_hit_mem_b)     fwd_b = 2'b10;
    else if (w_hit_wb_b) fwd_b = 2'b01;
  end

`ifdef LOAD_USE_DETECT_EN
  logic w_ex_ok;
  assign w_ex_ok = mem_to_reg_ex & reg_write_ex & ~(ZERO_GUARD & (wr_addr_ex == '0));
  assign load_use_stall = w_ex_ok & ((wr_addr_ex == rs_id) | (wr_addr_ex == rt_id));
`else
  // Software fills the load delay slot; ID sources are not needed here
  logic w_unused_id;
  assign w_unused_id    = ^{rs_id, rt_id};
  assign load_use_stall = 1'b0;
`endif

endmodule

// File: tb/tb_dest_reg_pipe.sv
// Directed bench for dest_reg_pipe; a second instance covers ZERO_GUARD=0.
module tb_dest_reg_pipe;
  logic       clk = 1'b0;
  logic       reset_n;
  logic [4:0] wr_addr_ex, rs_ex, rt_ex, rs_id, rt_id;
  logic       reg_write_ex, mem_to_reg_ex, hold_i, flush_i;

  logic [4:0] wr_addr_mem, wr_addr_wb;
  logic       reg_write_mem, mem_to_reg_mem, reg_write_wb, mem_to_reg_wb, load_use_stall;
  logic [1:0] fwd_a, fwd_b;

  logic [4:0] z_wr_addr_mem, z_wr_addr_wb;
  logic       z_reg_write_mem, z_mem_to_reg_mem, z_reg_write_wb, z_mem_to_reg_wb, z_stall;
  logic [1:0] z_fwd_a, z_fwd_b;

  int checks = 0;
  int errors = 0;

`ifdef LOAD_USE_DETECT_EN
  localparam bit LU = 1'b1;
`else
  localparam bit LU = 1'b0;
`endif

  always #5 clk = ~clk;

  dest_reg_pipe #(.ADDR_W(5), .ZERO_GUARD(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .wr_addr_ex(wr_addr_ex), .reg_write_ex(reg_write_ex),
    .mem_to_reg_ex(mem_to_reg_ex), .hold_i(hold_i), .flush_i(flush_i),
    .rs_ex(rs_ex), .rt_ex(rt_ex), .rs_id(rs_id), .rt_id(rt_id),
    .wr_addr_mem(wr_addr_mem), .reg_write_mem(reg_write_mem), .mem_to_reg_mem(mem_to_reg_mem),
    .wr_addr_wb(wr_addr_wb), .reg_write_wb(reg_write_wb), .mem_to_reg_wb(mem_to_reg_wb),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .load_use_stall(load_use_stall)
  );

  dest_reg_pipe #(.ADDR_W(5), .ZERO_GUARD(1'b0)) dut_nz (
    .clk(clk), .reset_n(reset_n), .wr_addr_ex(wr_addr_ex), .reg_write_ex(reg_write_ex),
    .mem_to_reg_ex(mem_to_reg_ex), .hold_i(hold_i), .flush_i(flush_i),
    .rs_ex(rs_ex), .rt_ex(rt_ex), .rs_id(rs_id), .rt_id(rt_id),
    .wr_addr_mem(z_wr_addr_mem), .reg_write_mem(z_reg_write_mem), .mem_to_reg_mem(z_mem_to_reg_mem),
    .wr_addr_wb(z_wr_addr_wb), .reg_write_wb(z_reg_write_wb), .mem_to_reg_wb(z_mem_to_reg_wb),
    .fwd_a(z_fwd_a), .fwd_b(z_fwd_b), .load_use_stall(z_stall)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ex(input logic [4:0] a, input logic rw, input logic m2r);
    wr_addr_ex    = a;
    reg_write_ex  = rw;
    mem_to_reg_ex = m2r;
  endtask

  initial begin
    reset_n = 1'b0;
    drive_ex(5'd0, 1'b0, 1'b0);
    hold_i = 0; flush_i = 0;
    rs_ex = 5'd31; rt_ex = 5'd31; rs_id = 5'd31; rt_id = 5'd31;
    #3;
    chk("rst_addr_mem", wr_addr_mem, 0);
    chk("rst_rw_wb", reg_write_wb, 0);
    chk("rst_fwd_a", fwd_a, 0);
    #10 reset_n = 1'b1;

    // basic forwarding: MEM then WB
    step();
    drive_ex(5'd8, 1'b1, 1'b0);
    step();
    drive_ex(5'd0, 1'b0, 1'b0);
    rs_ex = 5'd8; rt_ex = 5'd8;
    #1;
    chk("t2_addr_mem", wr_addr_mem, 8);
    chk("t2_fwd_a_mem", fwd_a, 2'b10);
    chk("t2_fwd_b_mem", fwd_b, 2'b10);
    step();
    chk("t2_fwd_a_wb", fwd_a, 2'b01);
    chk("t2_addr_wb", wr_addr_wb, 8);
    chk("t2_rw_wb", reg_write_wb, 1);
    rs_ex = 5'd9;
    #1;
    chk("t2_fwd_a_miss", fwd_a, 2'b00);

    // back-to-back writes to the same register: MEM wins
    drive_ex(5'd5, 1'b1, 1'b0);
    step();
    drive_ex(5'd5, 1'b1, 1'b0);
    step();
    drive_ex(5'd0, 1'b0, 1'b0);
    rs_ex = 5'd5; rt_ex = 5'd5;
    #1;
    chk("t3_fwd_a_both", fwd_a, 2'b10);
    chk("t3_fwd_b_both", fwd_b, 2'b10);
    step();
    chk("t3_fwd_a_wb", fwd_a, 2'b01);

    // r0 destination
    rs_ex = 5'd31; rt_ex = 5'd0;
    drive_ex(5'd0, 1'b1, 1'b0);
    step();
    drive_ex(5'd0, 1'b0, 1'b0);
    #1;
    chk("t4_zg_fwd_b_c1", fwd_b, 2'b00);
    chk("t4_nz_fwd_b_c1", z_fwd_b, 2'b10);
    step();
    chk("t4_zg_fwd_b_c2", fwd_b, 2'b00);
    chk("t4_nz_fwd_b_c2", z_fwd_b, 2'b01);
    rt_ex = 5'd31;
    step();

    // flush and hold
    drive_ex(5'd7, 1'b1, 1'b0);
    step();
    drive_ex(5'd12, 1'b1, 1'b0);
    flush_i = 1;
    step();
    flush_i = 0;
    chk("t5_flush_rw_mem", reg_write_mem, 0);
    chk("t5_flush_addr_mem", wr_addr_mem, 0);
    chk("t5_flush_addr_wb", wr_addr_wb, 7);
    drive_ex(5'd10, 1'b1, 1'b0);
    step();
    drive_ex(5'd12, 1'b1, 1'b0);
    flush_i = 1; hold_i = 1;
    step();
    step();
    chk("t5_hold_addr_mem", wr_addr_mem, 10);
    chk("t5_hold_rw_mem", reg_write_mem, 1);
    chk("t5_hold_addr_wb", wr_addr_wb, 0);
    chk("t5_hold_rw_wb", reg_write_wb, 0);
    flush_i = 0; hold_i = 0;

    // load-use detection
    drive_ex(5'd3, 1'b1, 1'b1);
    rs_id = 5'd3; rt_id = 5'd0;
    #1 chk("t6_rs_match", load_use_stall, LU);
    rs_id = 5'd4; rt_id = 5'd3;
    #1 chk("t6_rt_match", load_use_stall, LU);
    rs_id = 5'd4; rt_id = 5'd6;
    #1 chk("t6_no_match", load_use_stall, 0);
    drive_ex(5'd3, 1'b1, 1'b0);
    rs_id = 5'd3;
    #1 chk("t6_not_load", load_use_stall, 0);
    drive_ex(5'd0, 1'b1, 1'b1);
    rs_id = 5'd0;
    #1;
    chk("t6_zg_r0", load_use_stall, 0);
    chk("t6_nz_r0", z_stall, LU);
    drive_ex(5'd3, 1'b1, 1'b1);
    rs_id = 5'd31; rt_id = 5'd31;
    step();
    drive_ex(5'd0, 1'b0, 1'b0);
    chk("t6_m2r_mem", mem_to_reg_mem, 1);
    step();
    chk("t6_m2r_wb", mem_to_reg_wb, 1);
    chk("t6_m2r_mem_clr", mem_to_reg_mem, 0);

    // async reset mid-cycle
    drive_ex(5'd9, 1'b1, 1'b0);
    rs_ex = 5'd9;
    step();
    chk("t1_pre_addr_mem", wr_addr_mem, 9);
    #2 reset_n = 1'b0;
    #1;
    chk("t1_addr_mem", wr_addr_mem, 0);
    chk("t1_rw_mem", reg_write_mem, 0);
    chk("t1_addr_wb", wr_addr_wb, 0);
    chk("t1_fwd_a", fwd_a, 0);
    chk("t1_nz_rw_mem", z_reg_write_mem, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
